// File: rtl/shl_stage.sv
// shl_stage: valid/ready issue/capture stage around a combinational SHL unit, with overflow and completion tracking
module shl_stage #(
  parameter int DATAWIDTH = 16,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_sh_amt,
  output logic [DATAWIDTH-1:0] shl_a,
  output logic [DATAWIDTH-1:0] shl_sh_amt,
  input  logic [DATAWIDTH-1:0] shl_d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_d,
  output logic                 out_ovf,
  output logic                 ovf_sticky,
  output logic [CNTWIDTH-1:0]  done_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [DATAWIDTH-1:0] W = DATAWIDTH'(DATAWIDTH);
  state_t state, nxt;
  logic accept, take, ovf;
  assign take     = (state == DONE) & out_ready;
  assign in_ready = Rst & ((state == IDLE) | take);
  assign accept   = in_valid & in_ready;
  // overflow means some set bit of a lands at or beyond the top of the word
  always_comb begin
    ovf = (shl_sh_amt == '0) ? 1'b0 :
          (shl_sh_amt >= W)  ? |shl_a :
                               |(shl_a >> (W - shl_sh_amt));
    nxt = accept ? EXEC : (state == EXEC) ? DONE : take ? IDLE : state;
  end
  // sequencing: operands on accept, result capture in EXEC, bookkeeping on output handshake
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      shl_a      <= '0;
      shl_sh_amt <= '0;
      out_d      <= '0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      done_cnt   <= '0;
    end else begin
      state     <= nxt;
      out_valid <= nxt == DONE;
      if (accept) begin
        shl_a      <= in_a;
        shl_sh_amt <= in_sh_amt;
      end
      if (state == EXEC) begin
        out_d   <= shl_d;
        out_ovf <= ovf;
      end
      if (take) begin
        done_cnt   <= done_cnt + 1'b1;
        ovf_sticky <= ovf_sticky | out_ovf;
      end
    end
  end
endmodule

// File: tb/tb_shl_stage.sv
// tb_shl_stage: randomized scoreboard bench for shl_stage with a behavioural shift/overflow model
module tb_shl_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, ovf_sticky;
  logic [15:0] in_a, in_sh_amt, shl_a, shl_sh_amt, shl_d, out_d;
  logic [3:0]  done_cnt;
  int          compared = 0;
  int          mismatched = 0;

  shl_stage #(.DATAWIDTH(16), .CNTWIDTH(4)) dut (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_sh_amt(in_sh_amt), .shl_a(shl_a), .shl_sh_amt(shl_sh_amt),
    .shl_d(shl_d), .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .done_cnt(done_cnt)
  );

  // the external combinational SHL unit
  assign shl_d = shl_a << shl_sh_amt;

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // {ovf, d}: a times 2**sh, low 16 bits kept, ovf if anything remains above them
  function automatic logic [16:0] ref_shl(logic [15:0] a, logic [15:0] sh);
    longint full;
    if (sh >= 16) return {a != 0, 16'h0};
    full = longint'(a) * (longint'(1) << sh);
    return {(full >> 16) != 0, full[15:0]};
  endfunction

  logic [16:0] q[$];
  int          cyc = 0;
  int          acc_cyc = -10;
  int          cnt_m = 0;
  logic        stk_m = 1'b0;
  logic        prev_rst = 1'b1;
  logic        exp_v, exp_r;

  // monitor: model expectations sampled mid-cycle, handshakes resolved for the next edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 0);
      if (!prev_rst) begin
        chk("out_valid_rst", 32'(out_valid), 0);
        chk("done_cnt_rst", 32'(done_cnt), 0);
        chk("ovf_sticky_rst", 32'(ovf_sticky), 0);
        chk("out_d_rst", 32'(out_d), 0);
        chk("out_ovf_rst", 32'(out_ovf), 0);
        chk("shl_a_rst", 32'(shl_a), 0);
        chk("shl_sh_amt_rst", 32'(shl_sh_amt), 0);
      end
      q.delete();
      cnt_m = 0;
      stk_m = 1'b0;
      acc_cyc = -10;
    end else begin
      exp_v = q.size() > 0 && cyc != acc_cyc + 1;
      exp_r = q.size() == 0 || (exp_v && out_ready);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("in_ready", 32'(in_ready), 32'(exp_r));
      chk("done_cnt", 32'(done_cnt), 32'(cnt_m));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(stk_m));
      if (exp_v) begin
        chk("out_d", 32'(out_d), 32'(q[0][15:0]));
        chk("out_ovf", 32'(out_ovf), 32'(q[0][16]));
      end
      if (exp_v && out_ready) begin
        stk_m = stk_m | q[0][16];
        cnt_m = (cnt_m + 1) % 16;
        void'(q.pop_front());
      end
      if (in_valid && exp_r) begin
        q.push_back(ref_shl(in_a, in_sh_amt));
        acc_cyc = cyc;
      end
    end
    prev_rst = rst;
  end

  task automatic send(input logic [15:0] a, input logic [15:0] sh);
    bit ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_sh_amt = sh;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      mismatched++;
      $display("FAIL send_timeout: in_ready never rose for a=%0h sh=%0h", a, sh);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_sh_amt = '0;
    out_ready = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(2);
    send(16'h0003, 16'd4);
    idle(3);
    send(16'hC001, 16'd1);
    idle(3);
    send(16'h0001, 16'd16);
    idle(3);
    send(16'h0001, 16'hFFFF);
    idle(3);
    out_ready = 1'b0;
    send(16'h00F0, 16'd8);
    idle(7);
    in_valid = 1'b1;
    in_a = 16'h1234;
    in_sh_amt = 16'd3;
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    idle(4);
    send(16'hFFFF, 16'd15);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < 17; i++) send(16'(i * 37 + 1), 16'(i % 18));
    idle(3);
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_a = 16'($urandom);
      in_sh_amt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      out_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
